// File: rtl/fp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_issue_ctrl
// Purpose  : FP issue stage between the decoder and the FPNEW FPU. It captures
//            one decoded op, holds it until RAW/WAW hazards clear, dispatches
//            it with a writeback tag and tracks in-flight ops. Illegal ops are
//            absorbed and reported, never issued.
// Config   : FP_ISSUE_SCOREBOARD_EN enables the per-register pending
//            scoreboard. Without it the FPU runs fully serialized.
// Revision : 1.0 - initial release
// ============================================================================
module fp_issue_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dec_valid_i,
  output logic       dec_ready_o,
  input  logic       dec_illegal_i,
  input  logic [3:0] dec_op_i,
  input  logic       dec_op_mod_i,
  input  logic [2:0] dec_rm_i,
  input  logic [4:0] dec_raddr_a_i,
  input  logic [4:0] dec_raddr_b_i,
  input  logic [4:0] dec_raddr_c_i,
  input  logic       dec_uses_c_i,
  input  logic [4:0] dec_waddr_i,
  input  logic       dec_fp_write_i,
  output logic       fpu_valid_o,
  input  logic       fpu_ready_i,
  output logic [3:0] fpu_op_o,
  output logic       fpu_op_mod_o,
  output logic [2:0] fpu_rm_o,
  output logic [4:0] fpu_raddr_a_o,
  output logic [4:0] fpu_raddr_b_o,
  output logic [4:0] fpu_raddr_c_o,
  output logic [5:0] fpu_tag_o,
  input  logic       wb_valid_i,
  input  logic [5:0] wb_tag_i,
  output logic       illegal_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic             op_mod_q;
  logic [2:0]       rm_q;
  logic [4:0]       ra_q, rb_q, rc_q, waddr_q;
  logic             uses_c_q, fp_write_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             capture;
  logic             issue_hs;
  logic             cnt_full;
  logic             hazard;

  assign dec_ready_o = (state_q == IDLE);
  assign capture     = dec_valid_i && dec_ready_o;
  assign issue_hs    = (state_q == ISSUE) && fpu_ready_i;
  assign cnt_full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));

`ifdef FP_ISSUE_SCOREBOARD_EN
  logic [31:0] pending_q, pending_d;
  logic [31:0] set_vec, clr_vec;
  logic [4:0]  hz_ra, hz_rb, hz_rc, hz_wa;
  logic        hz_uses_c, hz_fpw;

  // Hazard check looks at the incoming op while idle, the held op otherwise
  always_comb begin
    hz_ra     = ra_q;
    hz_rb     = rb_q;
    hz_rc     = rc_q;
    hz_wa     = waddr_q;
    hz_uses_c = uses_c_q;
    hz_fpw    = fp_write_q;
    if (state_q == IDLE) begin
      hz_ra     = dec_raddr_a_i;
      hz_rb     = dec_raddr_b_i;
      hz_rc     = dec_raddr_c_i;
      hz_wa     = dec_waddr_i;
      hz_uses_c = dec_uses_c_i;
      hz_fpw    = dec_fp_write_i;
    end
  end

  // Only the registered scoreboard is consulted; a same-cycle clear waits a cycle
  assign hazard = pending_q[hz_ra] | pending_q[hz_rb]
                | (hz_uses_c & pending_q[hz_rc])
                | (hz_fpw & pending_q[hz_wa])
                | cnt_full;

  // Scoreboard next state: issue set is applied after writeback clear so set wins
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_hs && fp_write_q) set_vec[waddr_q] = 1'b1;
    if (wb_valid_i && wb_tag_i[5]) clr_vec[wb_tag_i[4:0]] = 1'b1;
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // Pending-register scoreboard
  always_ff @(posedge clk_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end
`else
  // Fully serialized: any op in flight blocks the next one (cnt_full is implied)
  assign hazard = (cnt_q != '0) | cnt_full;

  logic unused_ok;
  assign unused_ok = ^{uses_c_q, wb_tag_i};
`endif

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture && !dec_illegal_i) state_d = hazard ? STALL : ISSUE;
      STALL:   if (!hazard) state_d = ISSUE;
      ISSUE:   if (fpu_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture register for all decoder fields plus the illegal pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q       <= '0;
      op_mod_q   <= 1'b0;
      rm_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rc_q       <= '0;
      waddr_q    <= '0;
      uses_c_q   <= 1'b0;
      fp_write_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= capture && dec_illegal_i;
      if (capture) begin
        op_q       <= dec_op_i;
        op_mod_q   <= dec_op_mod_i;
        rm_q       <= dec_rm_i;
        ra_q       <= dec_raddr_a_i;
        rb_q       <= dec_raddr_b_i;
        rc_q       <= dec_raddr_c_i;
        waddr_q    <= dec_waddr_i;
        uses_c_q   <= dec_uses_c_i;
        fp_write_q <= dec_fp_write_i;
      end
    end
  end

  // Outstanding counter: issue and writeback in the same cycle cancel out
  always_comb begin
    cnt_d = cnt_q;
    if (issue_hs && !wb_valid_i)                      cnt_d = cnt_q + CNT_W'(1);
    else if (!issue_hs && wb_valid_i && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  // Outstanding counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign fpu_valid_o   = (state_q == ISSUE);
  assign fpu_op_o      = op_q;
  assign fpu_op_mod_o  = op_mod_q;
  assign fpu_rm_o      = rm_q;
  assign fpu_raddr_a_o = ra_q;
  assign fpu_raddr_b_o = rb_q;
  assign fpu_raddr_c_o = rc_q;
  assign fpu_tag_o     = {fp_write_q, waddr_q};
  assign illegal_o     = illegal_q;
  assign busy_o        = (state_q != IDLE) || (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_fp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_issue_ctrl
// Purpose  : Randomized self-checking bench for fp_issue_ctrl. A behavioural
//            model tracks pending registers, the in-flight count and the held
//            op; expected FPU transactions are queued and checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_issue_ctrl;
  localparam int MAXO = 4;
  localparam int CW   = 4;
  localparam int NCYC = 1600;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_ready, dec_illegal, dec_op_mod, dec_uses_c, dec_fp_write;
  logic [3:0] dec_op;
  logic [2:0] dec_rm;
  logic [4:0] dec_ra, dec_rb, dec_rc, dec_wa;
  logic       fpu_valid, fpu_ready, fpu_op_mod;
  logic [3:0] fpu_op;
  logic [2:0] fpu_rm;
  logic [4:0] fpu_ra, fpu_rb, fpu_rc;
  logic [5:0] fpu_tag;
  logic       wb_valid;
  logic [5:0] wb_tag;
  logic       illegal, busy;

  always #5 clk = ~clk;

  fp_issue_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_illegal_i(dec_illegal),
    .dec_op_i(dec_op), .dec_op_mod_i(dec_op_mod), .dec_rm_i(dec_rm),
    .dec_raddr_a_i(dec_ra), .dec_raddr_b_i(dec_rb), .dec_raddr_c_i(dec_rc),
    .dec_uses_c_i(dec_uses_c), .dec_waddr_i(dec_wa), .dec_fp_write_i(dec_fp_write),
    .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready),
    .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod), .fpu_rm_o(fpu_rm),
    .fpu_raddr_a_o(fpu_ra), .fpu_raddr_b_o(fpu_rb), .fpu_raddr_c_o(fpu_rc),
    .fpu_tag_o(fpu_tag), .wb_valid_i(wb_valid), .wb_tag_i(wb_tag),
    .illegal_o(illegal), .busy_o(busy)
  );

  typedef struct packed {
    logic [3:0] op;
    logic       mod;
    logic [2:0] rm;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rc;
    logic [5:0] tag;
  } fpu_rec_t;

  fpu_rec_t   exp_q[$];
  logic [5:0] inflight[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  // Reference model state
  bit       m_pend[32];
  int       m_cnt;
  bit       m_has_op, m_present, m_illegal, m_fields_zero;
  fpu_rec_t m_held;
  bit       m_held_uses_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input logic [4:0] ra, input logic [4:0] rb,
                                      input logic [4:0] rc, input bit uses_c,
                                      input bit fpw, input logic [4:0] wa);
`ifdef FP_ISSUE_SCOREBOARD_EN
    return m_pend[ra] || m_pend[rb] || (uses_c && m_pend[rc]) ||
           (fpw && m_pend[wa]) || (m_cnt == MAXO);
`else
    return m_cnt != 0;
`endif
  endfunction

  task automatic reset_model();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cnt = 0;
    m_has_op = 1'b0;
    m_present = 1'b0;
    m_illegal = 1'b0;
    m_fields_zero = 1'b1;
    exp_q.delete();
    inflight.delete();
  endtask

  // Advance the model across the clock edge that just happened, using the
  // inputs that were stable at that edge
  task automatic model_step();
    bit issue, cap, stall_clears, cap_hz;
    if (rst) begin
      reset_model();
      return;
    end
    issue        = m_present && fpu_ready;
    cap          = dec_valid && !m_has_op;
    stall_clears = m_has_op && !m_present &&
                   !model_hazard(m_held.ra, m_held.rb, m_held.rc, m_held_uses_c,
                                 m_held.tag[5], m_held.tag[4:0]);
    cap_hz       = model_hazard(dec_ra, dec_rb, dec_rc, dec_uses_c, dec_fp_write, dec_wa);
    m_illegal    = cap && dec_illegal;
    if (cap) m_fields_zero = 1'b0;
    if (issue) inflight.push_back(m_held.tag);
    if (wb_valid && wb_tag[5]) m_pend[wb_tag[4:0]] = 1'b0;
    if (issue && m_held.tag[5]) m_pend[m_held.tag[4:0]] = 1'b1;
    if (issue && !wb_valid) m_cnt++;
    else if (wb_valid && !issue && m_cnt > 0) m_cnt--;
    if (issue) begin
      m_has_op  = 1'b0;
      m_present = 1'b0;
    end else if (stall_clears) begin
      m_present = 1'b1;
    end
    if (cap && !dec_illegal) begin
      m_has_op      = 1'b1;
      m_held        = '{op: dec_op, mod: dec_op_mod, rm: dec_rm, ra: dec_ra, rb: dec_rb,
                        rc: dec_rc, tag: {dec_fp_write, dec_wa}};
      m_held_uses_c = dec_uses_c;
      m_present     = !cap_hz;
      exp_q.push_back(m_held);
    end
  endtask

  // Monitor: compare DUT outputs against the model mid-cycle
  initial begin
    fpu_rec_t got;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("dec_ready", 32'(dec_ready), 32'(!m_has_op));
        chk("fpu_valid", 32'(fpu_valid), 32'(m_present));
        chk("busy", 32'(busy), 32'(m_has_op || m_cnt != 0));
        chk("illegal", 32'(illegal), 32'(m_illegal));
        got = {fpu_op, fpu_op_mod, fpu_rm, fpu_ra, fpu_rb, fpu_rc, fpu_tag};
        if (m_fields_zero) chk("fields_after_reset", 32'(got), 32'd0);
        if (fpu_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_issue", 32'(fpu_valid), 32'd0);
          end else begin
            chk("fpu_fields", 32'(got), 32'(exp_q[0]));
            if (fpu_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int pwb, prdy, idx;
    rst = 1'b1;
    dec_valid = 1'b0; dec_illegal = 1'b0; dec_op = '0; dec_op_mod = 1'b0; dec_rm = '0;
    dec_ra = '0; dec_rb = '0; dec_rc = '0; dec_uses_c = 1'b0; dec_wa = '0;
    dec_fp_write = 1'b0; fpu_ready = 1'b0; wb_valid = 1'b0; wb_tag = '0;
    reset_model();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #2;
      model_step();
      mon_en = 1'b1;
      if (cyc < 400)       begin pwb = 30; prdy = 75; end
      else if (cyc < 700)  begin pwb = 3;  prdy = 90; end
      else if (cyc < 1100) begin pwb = 40; prdy = 30; end
      else                 begin pwb = 20; prdy = 60; end
      rst = (cyc < 2) || (cyc == 550) || (cyc == 900) || (cyc == 1300);
      dec_valid    = ($urandom_range(0, 99) < 60);
      dec_illegal  = ($urandom_range(0, 7) == 0);
      dec_op       = 4'($urandom_range(0, 15));
      dec_op_mod   = 1'($urandom_range(0, 1));
      dec_rm       = 3'($urandom_range(0, 7));
      dec_ra       = 5'($urandom_range(0, 7));
      dec_rb       = 5'($urandom_range(0, 7));
      dec_rc       = 5'($urandom_range(0, 7));
      dec_uses_c   = 1'($urandom_range(0, 1));
      dec_wa       = 5'($urandom_range(0, 7));
      dec_fp_write = ($urandom_range(0, 3) != 0);
      fpu_ready    = ($urandom_range(0, 99) < prdy);
      wb_valid     = 1'b0;
      wb_tag       = 6'($urandom_range(0, 63));
      if (m_present && fpu_ready && $urandom_range(0, 9) == 0) begin
        wb_valid = 1'b1;
        wb_tag   = m_held.tag;
      end else if (inflight.size() != 0 && $urandom_range(0, 99) < pwb) begin
        idx      = $urandom_range(0, inflight.size() - 1);
        wb_valid = 1'b1;
        wb_tag   = inflight[idx];
        inflight.delete(idx);
      end else if ($urandom_range(0, 99) < 3) begin
        wb_valid = 1'b1;
        wb_tag   = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))};
      end
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
